// File: rtl/rate_detector.sv
// rate_detector: recovers the 2-bit Speed code from the cycle spacing of Pulse strobes.
// Define RATE_DETECTOR_TOL_EN to accept +/-TOL around PERIOD1..PERIOD3 (class 0 stays exact).
module rate_detector #(
  parameter int unsigned PERIOD0    = 1,
  parameter int unsigned PERIOD1    = 500,
  parameter int unsigned PERIOD2    = 1000,
  parameter int unsigned PERIOD3    = 2000,
  parameter int unsigned TOL        = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic        ClockIn,
  input  logic        Clear_b,
  input  logic        Pulse,
  output logic [1:0]  Speed,
  output logic        Valid,
  output logic [10:0] Period,
  output logic        Timeout,
  output logic        Change
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  ARMED   = 2'd1;
  localparam logic [1:0]  LOCKED  = 2'd2;
  localparam logic [10:0] GAP_MAX = '1;
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_COUNT);

`ifdef RATE_DETECTOR_TOL_EN
  localparam bit TOL_EN = 1'b1;
`else
  localparam bit TOL_EN = 1'b0;
`endif

  // Exact matching is simply a zero-width window, so both builds share one classifier.
  localparam int unsigned WIN = TOL_EN ? TOL : 0;
  localparam int unsigned LO1 = (PERIOD1 > WIN) ? PERIOD1 - WIN : 0;
  localparam int unsigned HI1 = PERIOD1 + WIN;
  localparam int unsigned LO2 = (PERIOD2 > WIN) ? PERIOD2 - WIN : 0;
  localparam int unsigned HI2 = PERIOD2 + WIN;
  localparam int unsigned LO3 = (PERIOD3 > WIN) ? PERIOD3 - WIN : 0;
  localparam int unsigned HI3 = PERIOD3 + WIN;

  logic [1:0]  state, state_n;
  logic [10:0] gap, gap_n;
  logic [1:0]  cand, cand_n;
  logic [2:0]  cnt, cnt_n;
  logic [2:0]  cnt_inc;
  logic [1:0]  speed_n;
  logic        valid_n;
  logic [10:0] period_n;
  logic        timeout_n;
  logic        change_n;
  logic [31:0] p_ext;
  logic        cls_ok;
  logic [1:0]  cls;

  // Classify the interval currently held in gap (only consulted on a measuring Pulse).
  always_comb begin
    p_ext  = {21'd0, gap};
    cls_ok = 1'b1;
    cls    = 2'd0;
    if (p_ext == PERIOD0) begin
      cls = 2'd0;
    end else if (p_ext >= LO1 && p_ext <= HI1) begin
      cls = 2'd1;
    end else if (p_ext >= LO2 && p_ext <= HI2) begin
      cls = 2'd2;
    end else if (p_ext >= LO3 && p_ext <= HI3) begin
      cls = 2'd3;
    end else begin
      cls_ok = 1'b0;
    end
  end

  assign cnt_inc = cnt + 3'd1;

  always_comb begin
    state_n   = state;
    gap_n     = gap;
    cand_n    = cand;
    cnt_n     = cnt;
    speed_n   = Speed;
    valid_n   = Valid;
    period_n  = Period;
    timeout_n = 1'b0;
    change_n  = 1'b0;

    case (state)
      IDLE: begin
        if (Pulse) begin
          state_n = ARMED;
          gap_n   = 11'd1;
        end
      end

      ARMED, LOCKED: begin
        if (Pulse) begin
          gap_n    = 11'd1;
          period_n = gap;
          if (state == ARMED) begin
            if (!cls_ok) begin
              cnt_n = '0;
            end else if (cls == cand) begin
              cnt_n = cnt_inc;
            end else begin
              cand_n = cls;
              cnt_n  = 3'd1;
            end
            if (cls_ok && cnt_n == LOCK_N) begin
              state_n  = LOCKED;
              speed_n  = cand_n;
              valid_n  = 1'b1;
              change_n = 1'b1;
            end
          end else if (!(cls_ok && cls == Speed)) begin
            state_n = ARMED;
            valid_n = 1'b0;
            if (cls_ok) begin
              cand_n = cls;
              cnt_n  = 3'd1;
            end else begin
              cnt_n = '0;
            end
          end
        end else if (gap == GAP_MAX) begin
          // Strobe lost: a Pulse on this same cycle would have taken the branch above.
          state_n   = IDLE;
          gap_n     = '0;
          valid_n   = 1'b0;
          cnt_n     = '0;
          timeout_n = 1'b1;
        end else begin
          gap_n = gap + 11'd1;
        end
      end

      default: begin
        state_n = IDLE;
        gap_n   = '0;
        valid_n = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (!Clear_b) begin
      state   <= IDLE;
      gap     <= '0;
      cand    <= '0;
      cnt     <= '0;
      Speed   <= '0;
      Valid   <= 1'b0;
      Period  <= '0;
      Timeout <= 1'b0;
      Change  <= 1'b0;
    end else begin
      state   <= state_n;
      gap     <= gap_n;
      cand    <= cand_n;
      cnt     <= cnt_n;
      Speed   <= speed_n;
      Valid   <= valid_n;
      Period  <= period_n;
      Timeout <= timeout_n;
      Change  <= change_n;
    end
  end

endmodule

// File: tb/tb_rate_detector.sv
// Self-checking bench for rate_detector: timestamp-based reference model plus directed and random strobe spacing.
module tb_rate_detector;

  localparam int P0 = 1;
  localparam int P1 = 500;
  localparam int P2 = 1000;
  localparam int P3 = 2000;
  localparam int TOLV = 8;
  localparam int LOCKN = 2;
`ifdef RATE_DETECTOR_TOL_EN
  localparam int WINV = TOLV;
`else
  localparam int WINV = 0;
`endif

  logic        ClockIn = 1'b0;
  logic        Clear_b;
  logic        Pulse;
  logic [1:0]  Speed;
  logic        Valid;
  logic [10:0] Period;
  logic        Timeout;
  logic        Change;

  int tests = 0;
  int fails = 0;

  rate_detector #(
    .PERIOD0(P0), .PERIOD1(P1), .PERIOD2(P2), .PERIOD3(P3),
    .TOL(TOLV), .LOCK_COUNT(LOCKN)
  ) dut (
    .ClockIn(ClockIn), .Clear_b(Clear_b), .Pulse(Pulse),
    .Speed(Speed), .Valid(Valid), .Period(Period),
    .Timeout(Timeout), .Change(Change)
  );

  always #5 ClockIn = ~ClockIn;

  // Reference model: absolute edge timestamps, the trailing run of identical
  // interval classes, and lock whenever that run is long enough.
  int         cyc = 0;
  bit         started = 0;
  bit         active;
  int         t_last;
  int         run_len;
  int         run_cls;
  bit         m_valid;
  logic [1:0] m_speed;
  int         m_period;
  bit         m_timeout;
  bit         m_change;

  function automatic int classify(input int p);
    int per[4];
    per = '{P0, P1, P2, P3};
    if (p == per[0]) return 0;
    for (int k = 1; k < 4; k++) begin
      if (p >= per[k] - WINV && p <= per[k] + WINV) return k;
    end
    return -1;
  endfunction

  always @(posedge ClockIn) begin
    int p;
    int c;
    cyc++;
    m_timeout = 0;
    m_change  = 0;
    if (!Clear_b) begin
      started  = 1;
      active   = 0;
      run_len  = 0;
      run_cls  = 0;
      m_valid  = 0;
      m_speed  = 2'd0;
      m_period = 0;
    end else if (Pulse) begin
      if (active) begin
        p = cyc - t_last;
        m_period = p;
        c = classify(p);
        if (c < 0) begin
          run_len = 0;
        end else if (run_len > 0 && c == run_cls) begin
          run_len++;
        end else begin
          run_cls = c;
          run_len = 1;
        end
        if (m_valid && !(c >= 0 && c == int'(m_speed))) m_valid = 0;
        if (!m_valid && run_len >= LOCKN) begin
          m_valid  = 1;
          m_speed  = 2'(run_cls);
          m_change = 1;
        end
      end else begin
        active  = 1;
        run_len = 0;
      end
      t_last = cyc;
    end else if (active && cyc - t_last == 2047) begin
      active    = 0;
      m_valid   = 0;
      run_len   = 0;
      m_timeout = 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge ClockIn) begin
    if (started) begin
      chk("model.Speed",   32'(Speed),   32'(m_speed));
      chk("model.Valid",   32'(Valid),   32'(m_valid));
      chk("model.Period",  32'(Period),  32'(m_period));
      chk("model.Timeout", 32'(Timeout), 32'(m_timeout));
      chk("model.Change",  32'(Change),  32'(m_change));
    end
  end

  task automatic pulse_after(input int n);
    Pulse = 1'b0;
    repeat (n - 1) begin
      @(posedge ClockIn); #1;
    end
    Pulse = 1'b1;
    @(posedge ClockIn); #1;
    Pulse = 1'b0;
  endtask

  task automatic clear_once();
    Clear_b = 1'b0;
    @(posedge ClockIn); #1;
    Clear_b = 1'b1;
  endtask

  initial begin
    int n;
    int reps;
    int k;
    int per[4];
    per = '{P0, P1, P2, P3};
    Clear_b = 1'b0;
    Pulse   = 1'b0;
    repeat (3) @(posedge ClockIn);
    #1;
    chk("reset.Valid", 32'(Valid), 0);
    chk("reset.Speed", 32'(Speed), 0);
    chk("reset.Period", 32'(Period), 0);
    chk("reset.Flags", {30'd0, Timeout, Change}, 0);
    Clear_b = 1'b1;

    // Strobe every cycle: lock on third strobe at Speed 00.
    repeat (3) pulse_after(1);
    chk("fast.Valid", 32'(Valid), 1);
    chk("fast.Speed", 32'(Speed), 0);
    chk("fast.Period", 32'(Period), 1);
    chk("fast.Change", 32'(Change), 1);
    pulse_after(1);
    chk("fast.ChangeOnce", 32'(Change), 0);
    chk("fast.Hold", 32'(Valid), 1);

    // 1000-cycle spacing, then switch to 500.
    clear_once();
    pulse_after(1);
    pulse_after(1000);
    chk("p1000.NotYet", 32'(Valid), 0);
    pulse_after(1000);
    chk("p1000.Valid", 32'(Valid), 1);
    chk("p1000.Speed", 32'(Speed), 2);
    chk("p1000.Period", 32'(Period), 1000);
    pulse_after(500);
    chk("p500.Drop", 32'(Valid), 0);
    chk("p500.SpeedHeld", 32'(Speed), 2);
    chk("p500.Period", 32'(Period), 500);
    pulse_after(500);
    chk("p500.Relock", 32'(Valid), 1);
    chk("p500.Speed", 32'(Speed), 1);
    chk("p500.Change", 32'(Change), 1);

    // Off-nominal 1005 interval while locked at 10.
    pulse_after(1000);
    pulse_after(1000);
    chk("p1005.PreLock", 32'(Speed), 2);
    pulse_after(1005);
    chk("p1005.Period", 32'(Period), 1005);
`ifdef RATE_DETECTOR_TOL_EN
    chk("p1005.Valid", 32'(Valid), 1);
`else
    chk("p1005.Valid", 32'(Valid), 0);
`endif

    // Lock at 2000 then lose the strobe.
    pulse_after(2000);
    pulse_after(2000);
    chk("p2000.Valid", 32'(Valid), 1);
    chk("p2000.Speed", 32'(Speed), 3);
    Pulse = 1'b0;
    repeat (2046) @(posedge ClockIn);
    #1;
    chk("tmo.Early", {30'd0, Timeout, Valid}, 1);
    @(posedge ClockIn); #1;
    chk("tmo.Pulse", 32'(Timeout), 1);
    chk("tmo.Valid", 32'(Valid), 0);
    @(posedge ClockIn); #1;
    chk("tmo.OneCycle", 32'(Timeout), 0);
    pulse_after(5);
    chk("tmo.NoPeriodUpdate", 32'(Period), 2000);

    // Pulse on the cycle Gap reaches 2047.
    pulse_after(2000);
    pulse_after(2000);
    chk("g2047.PreLock", 32'(Valid), 1);
    pulse_after(2047);
    chk("g2047.Period", 32'(Period), 2047);
    chk("g2047.NoTimeout", 32'(Timeout), 0);
    chk("g2047.Unlock", 32'(Valid), 0);

    // Clear mid-lock with a coincident strobe.
    pulse_after(2000);
    pulse_after(2000);
    chk("clr.PreLock", {30'd0, Speed}, 3);
    Pulse = 1'b0;
    repeat (1999) @(posedge ClockIn);
    #1;
    Clear_b = 1'b0;
    Pulse   = 1'b1;
    @(posedge ClockIn); #1;
    chk("clr.Outputs", {18'd0, Speed, Valid, Period, Timeout, Change}, 0);
    Clear_b = 1'b1;
    pulse_after(7);
    chk("clr.IdleNoPeriod", 32'(Period), 0);

    // Random spacing runs, checked by the compare process every cycle.
    for (int seg = 0; seg < 16; seg++) begin
      case ($urandom_range(0, 6))
        0: n = 1;
        1: n = P1;
        2: n = P2;
        3: n = P3;
        4: begin
          k = int'($urandom_range(1, 3));
          n = per[k] + int'($urandom_range(0, 24)) - 12;
        end
        5: n = int'($urandom_range(2, 2047));
        default: n = int'($urandom_range(2040, 2100));
      endcase
      reps = int'($urandom_range(1, 3));
      repeat (reps) pulse_after(n);
    end

    repeat (4) @(posedge ClockIn);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
